// File: rtl/mini_alu_pkg.sv
// rtl/mini_alu_pkg.sv - shared state encoding and frame helpers for the ALU result transmitter
package mini_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic TX_IDLE = 1'b1;

  function automatic int FRAME_BITS(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction

endpackage

// File: rtl/alu_bit_timer.sv
// rtl/alu_bit_timer.sv - serial bit timer, one-cycle tick every CLKS_PER_BIT cycles
module alu_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      tick    = 1'b1;
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/alu_result_tx.sv
// rtl/alu_result_tx.sv - serialises an accepted ALU result word into a start/data/parity/stop frame
module alu_result_tx
  import mini_alu_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              tick;

  // Timer is held at zero in IDLE so the start bit gets a full bit period.
  alu_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_START;
          shreg_d   = in_data;
          bit_cnt_d = '0;
          parity_d  = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
        end
      end
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Line level is derived from the next state so tx itself comes straight from a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= TX_IDLE;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_STOP) && tick;

endmodule

// File: doc/alu_result_tx.md
Name: alu_result_tx

Overview:
- Transmit end of the Mini-ALU result path: takes a parallel ALU result word over a valid/ready handshake and sends it as a serial frame on one wire.
- Frame: start bit, DATA_W data bits LSB first, optional parity bit, stop bit.
- Parity is computed with an XOR/XNOR reduction of the accepted word.
- Sits after the ALU op-select mux; feeds a board pin or the matching serial receiver.

Parameters:
- DATA_W, 6, width of the ALU result word.
- CLKS_PER_BIT, 16, clock cycles each serial bit is held; legal values are >= 2.
- PARITY_EN, 1, 1 = parity bit inserted after the data bits; 0 = no parity bit.
- PARITY_ODD, 1, 1 = odd parity (bit = ~^data); 0 = even parity (bit = ^data).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  ALU result word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: clk is one clock; rst_n is asynchronous and active-low.
  - While rst_n is low: state = IDLE, tx = 1, busy = 0, frame_done = 0, in_ready = 1.
  - Shift register, bit counter and timer are cleared to 0.
  - No word is accepted while rst_n is low.
- Reset mid-frame: tx returns high immediately (asynchronously), the frame is abandoned, frame_done does not pulse, and no partial frame resumes after release.
- Handshake:
  - A word is accepted on the rising edge where in_valid && in_ready; in_data is captured into the shift register on that edge.
  - in_valid while busy is ignored; the block does not queue a word.
  - Upstream holds in_data stable until acceptance.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when PARITY_EN = 0 (DATA -> STOP).
  - IDLE: tx = 1. On accept, go to START with timer = 0.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: tx = shreg[0]. Shift right when the timer wraps. Leave after DATA_W bits, using a bit counter of width clog2(DATA_W+1).
  - PARITY: tx = parity latched at acceptance, for CLKS_PER_BIT cycles.
  - STOP: tx = 1 for CLKS_PER_BIT cycles; frame_done = 1 in its final cycle; then go to IDLE.
- Bit timing:
  - The timer counts 0..CLKS_PER_BIT-1; a bit boundary occurs when it reaches CLKS_PER_BIT-1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - tx is registered (glitch-free).
- Latency:
  - tx falls the cycle after the accept edge.
  - Frame length N = DATA_W + 2 + PARITY_EN bits, i.e. N*CLKS_PER_BIT cycles.
  - Back-to-back period is N*CLKS_PER_BIT + 1 cycles: one idle-high cycle in IDLE, where the next accept happens.
- Parity: computed from the captured word only, never from the shifting register.

Decomposition:
- Package mini_alu_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - the FRAME_BITS function of DATA_W and PARITY_EN;
  - TX_IDLE = 1'b1.
- One sub-module, alu_bit_timer:
  - parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick;
  - tick is a one-cycle pulse when the count reaches CLKS_PER_BIT-1, then the count wraps to 0.
- The FSM, shift register and parity logic stay in alu_result_tx.

Test Plan:
- Odd parity frame (CLKS_PER_BIT=4, PARITY_ODD=1): accept 6'b101101 at cycle 0.
  - tx per 4-cycle bit = 0,1,0,1,1,0,1,1,1 (start, data LSB first, parity 1, stop), over cycles 1..36.
  - frame_done pulses at cycle 36.
- Even parity and zero word:
  - PARITY_ODD=0 with 6'b101101 -> parity bit 0.
  - PARITY_ODD=1 with 6'b000000 -> data bits all 0, parity bit 1.
  - PARITY_EN=0 -> frame is 8 bits (32 cycles) with no parity bit.
- Back-to-back (CLKS_PER_BIT=4): in_valid held high with 6'h3F then 6'h15.
  - Second accept at cycle 37; second start bit drives tx = 0 at cycle 38.
  - in_ready is high only at cycles 0 and 37.
- Busy ignore: pulse in_valid with 6'h2A at cycle 10 of an active frame -> no effect on tx, no second frame; busy stays 1 until cycle 36.
- Reset mid-frame: pull rst_n low during data bit 3.
  - tx = 1, busy = 0, in_ready = 1 in the same cycle, asynchronously; no frame_done pulse.
  - After release, accepting 6'h01 yields a complete, correct frame.
- Minimum timing: CLKS_PER_BIT=2 -> every bit is exactly 2 cycles; 18-cycle frame; no dropped or duplicated bits.
